// File: rtl/servo_pos_ctrl.sv
// rtl/servo_pos_ctrl.sv - slew-limited servo position command with handshake targets and auto-sweep
// Position moves at most one index per STEP_FRAMES PWM frames; the PWM stage decodes oPWM_Control_Sig.
module servo_pos_ctrl #(
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int STEP_FRAMES  = 5,
  parameter int POS_MAX      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] iTarget,
  input  logic       iTarget_valid,
  output logic       oTarget_ready,
  input  logic       iSweep_en,
  output logic [7:0] oPWM_Control_Sig,
  output logic       oBusy,
  output logic       oFrame_tick
);
  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int SW = $clog2(STEP_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_FRAMES - 1);
  localparam logic [7:0]    POS_TOP    = 8'(POS_MAX);

  typedef enum logic [1:0] {IDLE, SLEW, SWEEP_UP, SWEEP_DOWN} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [SW-1:0] step_q, step_d;
  logic [7:0]    pos_q, pos_d;
  logic [7:0]    target_q, target_d;
  logic          tick, step, ready, accept;
  logic [7:0]    clamped;

  always_comb begin
    tick    = (frame_q == FRAME_LAST);
    frame_d = tick ? '0 : frame_q + FW'(1);
    step    = tick && (step_q == STEP_LAST);
    ready   = (state_q == IDLE) || (state_q == SLEW);
    accept  = iTarget_valid && ready;
    clamped = (iTarget > POS_TOP) ? POS_TOP : iTarget;

    state_d  = state_q;
    pos_d    = pos_q;
    target_d = target_q;

    case (state_q)
      IDLE, SLEW: begin
        // Sweep request wins; a same-cycle target is dropped.
        if (iSweep_en) begin
          state_d = (pos_q == POS_TOP) ? SWEEP_DOWN : SWEEP_UP;
        end else begin
          if (accept) target_d = clamped;
          if (state_q == IDLE) begin
            if (accept && (clamped != pos_q)) state_d = SLEW;
          end else if (accept ? (clamped == pos_q) : (pos_q == target_q)) begin
            state_d = IDLE;
          end else if (step && (pos_q != target_q)) begin
            pos_d = (target_q > pos_q) ? pos_q + 8'd1 : pos_q - 8'd1;
          end
        end
      end
      SWEEP_UP: begin
        if (!iSweep_en) begin
          state_d  = IDLE;
          target_d = pos_q;
        end else if (step) begin
          if (pos_q < POS_TOP) pos_d = pos_q + 8'd1;
          if (pos_d == POS_TOP) state_d = SWEEP_DOWN;
        end
      end
      SWEEP_DOWN: begin
        if (!iSweep_en) begin
          state_d  = IDLE;
          target_d = pos_q;
        end else if (step) begin
          if (pos_q != 8'd0) pos_d = pos_q - 8'd1;
          if (pos_d == 8'd0) state_d = SWEEP_UP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame ticks only accumulate while moving; any state change restarts the step interval.
    if ((state_q == IDLE) || (state_d != state_q)) begin
      step_d = '0;
    end else if (tick) begin
      step_d = step ? '0 : step_q + SW'(1);
    end else begin
      step_d = step_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      frame_q  <= '0;
      step_q   <= '0;
      pos_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      step_q   <= step_d;
      pos_q    <= pos_d;
      target_q <= target_d;
    end
  end

  assign oTarget_ready    = ready;
  assign oBusy            = (state_q != IDLE);
  assign oFrame_tick      = tick;
  assign oPWM_Control_Sig = pos_q;

endmodule

// File: doc/servo_pos_ctrl.md
Name: servo_pos_ctrl

Overview:
- Upstream command stage for the servo PWM generator: produces the 8-bit position index (0..POS_MAX) that the PWM block decodes into a 0.5-2.5 ms pulse in a 20 ms frame.
- Slew-limits position changes to one index per STEP_FRAMES PWM frames, so the servo never jumps.
- Offers an auto-sweep mode (triangle 0..POS_MAX..0).
- Accepts new targets over a valid/ready handshake.

Parameters:
- FRAME_CYCLES, 1_000_000, clocks per PWM frame (20 ms at 50 MHz).
- STEP_FRAMES, 5, frame ticks per one-index position step; must be >= 1.
- POS_MAX, 8, highest legal position index.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous reset, active-high.
- iTarget  input  8  requested position index.
- iTarget_valid  input  1  iTarget is valid this cycle.
- oTarget_ready  output  1  target can be accepted this cycle.
- iSweep_en  input  1  level; 1 = auto-sweep mode.
- oPWM_Control_Sig  output  8  current position index, fed to the PWM stage.
- oBusy  output  1  1 while in SLEW, SWEEP_UP or SWEEP_DOWN.
- oFrame_tick  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset: oPWM_Control_Sig=0, internal target=0, frame count=0, step count=0, state IDLE, oBusy=0, oFrame_tick=0, oTarget_ready=1. Reset overrides every other input in that cycle.
- Frame counter: free-running 0..FRAME_CYCLES-1, then wraps to 0. oFrame_tick=1 exactly in cycles where the count equals FRAME_CYCLES-1. It is never stalled by state.
- Handshake:
  - oTarget_ready = 1 in IDLE and SLEW, 0 in the sweep states.
  - Accept when valid && ready. The accepted value is clamped: values > POS_MAX store POS_MAX.
  - Valid without ready is ignored; there is no queueing.
- Step counter: counts frame ticks in SLEW and both sweep states. It is cleared in IDLE and on every state change. A step occurs on a frame tick with step count == STEP_FRAMES-1; the count then returns to 0.
- Position update: a step changes oPWM_Control_Sig by exactly ±1, registered, visible the cycle after the tick.
- State IDLE:
  - iSweep_en=1 → SWEEP_UP, or SWEEP_DOWN if pos==POS_MAX.
  - Otherwise, an accepted target != pos → SLEW. An accepted target == pos stays in IDLE.
- State SLEW:
  - Each step moves pos toward the target.
  - When the stepped pos equals the target, the next state is IDLE.
  - An accepted target replaces the old one immediately; the step counter is not cleared. If the new target equals the current pos → IDLE next cycle. Direction reverses if needed at the next step.
  - iSweep_en=1 → sweep, with priority over a same-cycle handshake; that target is discarded.
- State SWEEP_UP: steps +1. A step producing POS_MAX → SWEEP_DOWN.
- State SWEEP_DOWN: steps -1. A step producing 0 → SWEEP_UP.
- Sweep exit: iSweep_en=0 in either sweep state → IDLE next cycle, target <= current pos, pos held.
- Simultaneous step and accepted target: the step uses the old target; the new target is stored for subsequent steps.
- Widths: position is 8-bit unsigned and never leaves 0..POS_MAX. No wrap-around in any state.

Test Plan:
- Bench uses FRAME_CYCLES=10, STEP_FRAMES=2, POS_MAX=8; cycle 0 is the first cycle after rst deasserts.
- 1. Reset then idle → oPWM_Control_Sig=0, oTarget_ready=1, oBusy=0. oFrame_tick high at cycles 9, 19, 29 only.
- 2. iTarget=3 with valid at cycle 0 → oBusy=1 from cycle 1. pos becomes 1 at cycle 20, 2 at cycle 40, 3 at cycle 60. oBusy=0 from cycle 61.
- 3. iTarget=200 accepted in IDLE → stored target 8. pos ramps one index per 2 frames and stops at 8, never exceeding it.
- 4. Retarget mid-slew: slewing 0→6, at pos=2 accept iTarget=1 → next step gives pos=1, then IDLE. Re-accepting 1 while at pos=1 keeps IDLE with no step.
- 5. Sweep:
  - iSweep_en=1 from pos 0 → oTarget_ready=0, pos 0,1,…,8,7,…,0,1, one change per 2 frames. A valid target during sweep is ignored.
  - Drop iSweep_en at pos 5 → IDLE, pos holds 5, oTarget_ready=1.
- 6. Assert rst for one cycle during SLEW at pos 4 → next cycle pos=0, IDLE, oBusy=0, frame count restarted (next oFrame_tick 9 cycles after rst deasserts).
